int_arbiter: RTL

//   Parametrised interrupt arbiter and EXL sequencer for the 5-stage pipeline. It replaces the

---
 rtl/int_arbiter_if.sv | 30 +++
 rtl/int_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/int_arbiter_if.sv
// Handshake bundle between the pipeline controller / CP0 and the interrupt arbiter.
// The controller side uses the master modport; the arbiter uses the slave modport.
interface int_arbiter_if #(
  parameter int N_IRQ = 6,
  parameter int IDX_W = 3
);
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] im;
  logic             ie;
  logic [N_IRQ-1:0] ip_clr;
  logic             uncertain_jump;
  logic             pipeline_stall;
  logic             eret;
  logic             exl_set;
  logic             exl_clr;
  logic             exl;
  logic [N_IRQ-1:0] ip;
  logic [IDX_W-1:0] cause_idx;
  logic             fetch_hold;

  modport master (
    output irq, im, ie, ip_clr, uncertain_jump, pipeline_stall, eret,
    input  exl_set, exl_clr, exl, ip, cause_idx, fetch_hold
  );

  modport slave (
    input  irq, im, ie, ip_clr, uncertain_jump, pipeline_stall, eret,
    output exl_set, exl_clr, exl, ip, cause_idx, fetch_hold
  );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt arbiter and EXL sequencer: latches N level/edge sources, masks and prioritises them,
// defers entry across unresolved control flow or stalls, and holds fetch when deferral runs long.
module int_arbiter #(
  parameter int               N_IRQ       = 6,
  parameter logic [N_IRQ-1:0] IRQ_EDGE    = '0,
  parameter int               DEFER_LIMIT = 15,
  parameter int               IDX_W       = 3
) (
  input  logic          clk,
  input  logic          reset,
  int_arbiter_if.slave  bus
);

  localparam int              CNT_W   = (DEFER_LIMIT < 1) ? 1 : $clog2(DEFER_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(DEFER_LIMIT);
  localparam bit              HOLD_EN = (DEFER_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DEFER   = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [N_IRQ-1:0] irq_q,       irq_d;
  logic [N_IRQ-1:0] ip_q,        ip_d;
  logic [CNT_W-1:0] defer_cnt_q, defer_cnt_d;
  logic [IDX_W-1:0] cause_idx_q, cause_idx_d;

  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] sel_vec;
  logic [N_IRQ-1:0] take_vec;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] edge_next;
  logic [IDX_W-1:0] sel;
  logic             any_elig;
  logic             take;

  // Arbitration: eligibility, fixed priority (index 0 wins) and the take decision.
  always_comb begin
    elig     = (bus.ie && state_q != ST_HANDLER) ? (ip_q & bus.im) : '0;
    any_elig = |elig;
    // Isolate the lowest set bit; this is the winner as a one-hot vector.
    sel_vec  = elig & (~elig + N_IRQ'(1));
    sel      = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDX_W'(i);
    end
    take     = any_elig && !bus.uncertain_jump && !bus.pipeline_stall && !bus.eret;
    take_vec = take ? sel_vec : '0;
  end

  // Pending vector: level lines follow the pin, edge lines latch a rising edge until cleared.
  // A new edge is OR-ed in after the clear so it survives a simultaneous mtc0 or take.
  always_comb begin
    irq_d     = bus.irq;
    rise      = bus.irq & ~irq_q;
    edge_next = (ip_q & ~(bus.ip_clr | take_vec)) | rise;
    ip_d      = (IRQ_EDGE & edge_next) | (~IRQ_EDGE & bus.irq);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    defer_cnt_d = defer_cnt_q;
    cause_idx_d = cause_idx_q;

    unique case (state_q)
      ST_RUN: begin
        if (take) begin
          state_d = ST_HANDLER;
        end else if (any_elig) begin
          state_d     = ST_DEFER;
          defer_cnt_d = '0;
        end
      end
      ST_DEFER: begin
        if (take) begin
          state_d = ST_HANDLER;
        end else if (!any_elig) begin
          state_d     = ST_RUN;
          defer_cnt_d = '0;
        end else if (defer_cnt_q < LIMIT_C) begin
          defer_cnt_d = defer_cnt_q + CNT_W'(1);
        end
      end
      ST_HANDLER: begin
        if (bus.eret) state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_RUN;
        defer_cnt_d = '0;
      end
    endcase

    if (take) begin
      cause_idx_d = sel;
      defer_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset clears all state, including pending bits, so a reset mid-handler starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      irq_q       <= '0;
      ip_q        <= '0;
      defer_cnt_q <= '0;
      cause_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      ip_q        <= ip_d;
      defer_cnt_q <= defer_cnt_d;
      cause_idx_q <= cause_idx_d;
    end
  end

  assign bus.exl_set    = take;
  assign bus.exl_clr    = bus.eret;
  assign bus.exl        = (state_q == ST_HANDLER);
  assign bus.ip         = ip_q;
  assign bus.cause_idx  = cause_idx_q;
  assign bus.fetch_hold = HOLD_EN && (state_q == ST_DEFER) && (defer_cnt_q >= LIMIT_C) && !take;

endmodule
